// File: rtl/alu_op_sequencer.sv
// Operand loader and result stage for the 4-bit ALU.
// Collects A, B and the function select as three input nibbles, runs one execute cycle, then holds the result until it is taken.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       sel,
    input  logic [WIDTH-1:0] y,
    input  logic             cy,
    output logic [WIDTH-1:0] res,
    output logic             res_c,
    output logic             res_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNTW-1:0]  cnt
);

    typedef enum logic [2:0] {
        LD_A  = 3'd0,
        LD_B  = 3'd1,
        LD_OP = 3'd2,
        EXEC  = 3'd3,
        HOLD  = 3'd4
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       sel_q;
    logic             res_c_q, res_z_q, res_valid_q;
    logic [CNTW-1:0]  cnt_q;

    // The handshake outputs are decoded from the state alone, so they never depend on in_valid.
    assign in_ready = (state_q == LD_A) || (state_q == LD_B) || (state_q == LD_OP);
    assign busy     = (state_q != LD_A);

    // NOTE: every register is cleared by the asynchronous reset, so a pending result is discarded and cnt does not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_A;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            res_q       <= '0;
            res_c_q     <= 1'b0;
            res_z_q     <= 1'b0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                LD_A: if (in_valid) begin
                    a_q     <= in_data;
                    state_q <= LD_B;
                end
                LD_B: if (in_valid) begin
                    b_q     <= in_data;
                    state_q <= LD_OP;
                end
                LD_OP: if (in_valid) begin
                    sel_q   <= in_data[3:0];
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q       <= y;
                    res_c_q     <= cy;
                    res_z_q     <= (y == '0);
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    cnt_q       <= cnt_q + 1'b1;
                    state_q     <= LD_A;
                end
                default: state_q <= LD_A;
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign sel       = sel_q;
    assign res       = res_q;
    assign res_c     = res_c_q;
    assign res_z     = res_z_q;
    assign res_valid = res_valid_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural 16-function ALU drives y/cy from the registered operands.
// Every operation is checked against a transaction-level model of the load / execute / hold sequence.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a, b, sel;
    logic [3:0] y;
    logic       cy;
    logic [3:0] res;
    logic       res_c, res_z, res_valid;
    logic       res_ready = 1'b0;
    logic       busy;
    logic [7:0] cnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(4), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .y(y), .cy(cy),
        .res(res), .res_c(res_c), .res_z(res_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .cnt(cnt)
    );

    // Behavioural function units: {carry, result}.
    function automatic logic [4:0] alu_fn(input logic [3:0] x, input logic [3:0] z, input logic [3:0] s);
        case (s)
            4'd0:    return {1'b0, x} + {1'b0, z};
            4'd1:    return {(x < z), 4'(x - z)};
            4'd2:    return {1'b0, x & z};
            4'd3:    return {1'b0, x | z};
            4'd4:    return {1'b0, ~x};
            4'd5:    return {1'b0, x ^ z};
            4'd6:    return {1'b0, ~(x & z)};
            4'd7:    return {1'b0, ~(x | z)};
            4'd8:    return {1'b0, x};
            4'd9:    return {1'b0, z};
            4'd10:   return {1'b0, x} + 5'd1;
            4'd11:   return {x[3], x[2:0], 1'b0};
            4'd12:   return {x[0], 1'b0, x[3:1]};
            4'd13:   return {1'b0, ~(x ^ z)};
            4'd14:   return 5'd0;
            default: return 5'h0F;
        endcase
    endfunction

    always_comb {cy, y} = alu_fn(a, b, sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one nibble after `gap` idle cycles; returns at the negedge after the transfer edge.
    task automatic send(input logic [3:0] v, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        check("in_ready_load", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic do_op(input logic [3:0] opa, input logic [3:0] opb, input logic [3:0] op,
                         input int gap_a, input int gap_b, input int gap_op, input int rdly);
        logic [4:0] e;
        e = alu_fn(opa, opb, op);
        check("idle_busy", 32'(busy), 32'd0);
        send(opa, gap_a);
        check("a", 32'(a), 32'(opa));
        check("busy_ld", 32'(busy), 32'd1);
        send(opb, gap_b);
        check("b", 32'(b), 32'(opb));
        for (int i = 0; i < gap_op; i++) begin
            @(negedge clk);
            check("b_stall", 32'(b), 32'(opb));
            check("ready_stall", 32'(in_ready), 32'd1);
        end
        send(op, 0);
        check("sel", 32'(sel), 32'(op));
        check("exec_ready", 32'(in_ready), 32'd0);
        check("exec_valid", 32'(res_valid), 32'd0);
        res_ready = (rdly == 0);
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'd1);
        check("res", 32'(res), 32'(e[3:0]));
        check("res_c", 32'(res_c), 32'(e[4]));
        check("res_z", 32'(res_z), 32'(e[3:0] == 4'd0));
        check("hold_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= rdly; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_res", 32'({res_c, res_z, res}), 32'({e[4], e[3:0] == 4'd0, e[3:0]}));
            check("hold_busy", 32'({in_ready, busy}), 32'b01);
            if (k == rdly) res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("post_valid", 32'(res_valid), 32'd0);
        check("cnt", 32'(cnt), 32'(exp_cnt));
        check("post_ready", 32'({in_ready, busy}), 32'b10);
        check("res_kept", 32'(res), 32'(e[3:0]));
    endtask

    task automatic check_cleared(input string tag);
        check(tag, 32'({a, b, sel, res, res_c, res_z, res_valid, busy, cnt}), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        check_cleared("reset_vals");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'hA, 4'h6, 4'h5, 0, 0, 0, 0);
        check("xor_cnt", 32'(cnt), 32'd1);
        do_op(4'h9, 4'h7, 4'h0, 0, 0, 0, 0);
        check("add_zero_carry", 32'({res_c, res_z, res}), 32'b110000);
        do_op(4'h3, 4'hC, 4'h1, 1, 0, 3, 10);

        // Reset while a result is pending in HOLD.
        send(4'h5, 0);
        send(4'h2, 0);
        send(4'h3, 0);
        @(negedge clk);
        check("hold_before_rst", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        check_cleared("rst_hold_rel");

        // Reset after A and B have been accepted.
        send(4'hE, 0);
        send(4'h7, 0);
        rst_n = 1'b0;
        #1 check("rst_load_ab", 32'({a, b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_load_nores", 32'({res_valid, cnt}), 32'd0);
        do_op(4'hE, 4'h7, 4'h3, 0, 0, 0, 0);

        for (int n = 1; n < 256; n++)
            do_op(4'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        check("cnt_wrap", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
